// File: rtl/gate_seq_pkg.sv
// Shared types and truth-table reference for the gate bank self-test sequencer.
// Defines the FSM states, the vector count and the expected bank output.
package gate_seq_pkg;

    localparam int NUM_VECTORS = 4;
    localparam int GATE_W      = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } gate_state_e;

    // Bit order: NOT, NOT, OR, AND, XOR, XNOR.
    function automatic logic [GATE_W-1:0] gate_expected(input logic a, input logic b);
        return {~(a ^ b), a ^ b, a & b, a | b, ~a, ~a};
    endfunction

endpackage

// File: rtl/gate_bank_sequencer.sv
// Self-test controller: walks the four operand pairs through the gate bank,
// compares each settled result with the truth table and records failures.
module gate_bank_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int GATE_W        = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_out,
    output logic              a,
    output logic              b,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [GATE_W-1:0] err_mask,
    output logic              fail_valid,
    output logic [1:0]        fail_vec
);

    import gate_seq_pkg::*;

    gate_state_e       state_q;
    logic [1:0]        vec_q;
    logic [3:0]        cnt_q;
    logic              a_q;
    logic              b_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [GATE_W-1:0] err_q;
    logic              fv_q;
    logic [1:0]        fvec_q;

    logic [GATE_W-1:0] mism_d;
    logic [GATE_W-1:0] err_d;
    logic [1:0]        vec_d;
    logic              settled_d;
    logic              last_vec_d;

    assign mism_d     = gate_out ^ gate_expected(a_q, b_q);
    assign err_d      = err_q | mism_d;
    assign vec_d      = vec_q + 2'd1;
    assign settled_d  = (cnt_q == 4'(SETTLE_CYCLES - 1));
    assign last_vec_d = (vec_q == 2'(NUM_VECTORS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= 2'd0;
            cnt_q   <= 4'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            fvec_q  <= 2'd0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_q <= SETTLE;
                        vec_q   <= 2'd0;
                        cnt_q   <= 4'd0;
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                        busy_q  <= 1'b1;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                        fv_q    <= 1'b0;
                        fvec_q  <= 2'd0;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        state_q <= IDLE;
                        cnt_q   <= 4'd0;
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                        if (settled_d) begin
                            state_q <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    // An aborted check leaves the partial results untouched.
                    if (abort) begin
                        state_q <= IDLE;
                        cnt_q   <= 4'd0;
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else begin
                        err_q <= err_d;
                        if (mism_d != '0 && !fv_q) begin
                            fv_q   <= 1'b1;
                            fvec_q <= vec_q;
                        end
                        if (last_vec_d) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == '0);
                        end else begin
                            state_q <= SETTLE;
                            vec_q   <= vec_d;
                            a_q     <= vec_d[1];
                            b_q     <= vec_d[0];
                            cnt_q   <= 4'd0;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign a          = a_q;
    assign b          = b_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_mask   = err_q;
    assign fail_valid = fv_q;
    assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_gate_bank_sequencer.sv
// Directed bench for gate_bank_sequencer: fault-free and faulty gate banks,
// ignored start, abort, SETTLE_CYCLES=1 and mid-run reset.
module tb_gate_bank_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start2, abort2, start1, abort1;
    logic [5:0] f0, f1;

    logic       d2_a, d2_b, d2_busy, d2_done, d2_pass, d2_fv;
    logic [5:0] d2_err;
    logic [1:0] d2_fvec;
    logic       d1_a, d1_b, d1_busy, d1_done, d1_pass, d1_fv;
    logic [5:0] d1_err;
    logic [1:0] d1_fvec;
    logic [5:0] g2, g1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Behavioural gate banks with stuck-at-0 (f0) and stuck-at-1 (f1) masks.
    assign g2 = ({~(d2_a ^ d2_b), d2_a ^ d2_b, d2_a & d2_b, d2_a | d2_b, ~d2_a, ~d2_a} & ~f0) | f1;
    assign g1 = ({~(d1_a ^ d1_b), d1_a ^ d1_b, d1_a & d1_b, d1_a | d1_b, ~d1_a, ~d1_a} & ~f0) | f1;

    gate_bank_sequencer #(.SETTLE_CYCLES(2), .GATE_W(6)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .gate_out(g2),
        .a(d2_a), .b(d2_b), .busy(d2_busy), .done(d2_done), .pass(d2_pass),
        .err_mask(d2_err), .fail_valid(d2_fv), .fail_vec(d2_fvec)
    );

    gate_bank_sequencer #(.SETTLE_CYCLES(1), .GATE_W(6)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .gate_out(g1),
        .a(d1_a), .b(d1_b), .busy(d1_busy), .done(d1_done), .pass(d1_pass),
        .err_mask(d1_err), .fail_valid(d1_fv), .fail_vec(d1_fvec)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Edge 0 samples start; inj adds a second start at that edge,
    // abt aborts at that edge and ends the run there.
    task automatic run(input bit s1, input int inj, input int abt,
                       output int done_at, output int ndone, output logic [7:0] abq);
        int per;
        per     = s1 ? 2 : 3;
        done_at = -1;
        ndone   = 0;
        abq     = 8'h00;
        for (int e = 0; e <= 20; e++) begin
            @(negedge clk);
            if (s1) begin
                start1 = (e == 0 || e == inj);
                abort1 = (e == abt);
            end else begin
                start2 = (e == 0 || e == inj);
                abort2 = (e == abt);
            end
            @(posedge clk);
            #1;
            start1 = 1'b0; abort1 = 1'b0;
            start2 = 1'b0; abort2 = 1'b0;
            if (s1 ? d1_done : d2_done) begin
                ndone++;
                if (done_at < 0) done_at = e;
            end
            if (e % per == 1 && e / per < 4)
                abq[2*(e/per) +: 2] = s1 ? {d1_a, d1_b} : {d2_a, d2_b};
            if (e == abt) break;
        end
    endtask

    int         dat, nd;
    logic [7:0] abq;

    initial begin
        rst_n = 1'b0;
        start2 = 1'b0; abort2 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        f0 = 6'h00; f1 = 6'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", d2_busy, 0);
        chk("rst_done", d2_done, 0);
        chk("rst_pass", d2_pass, 0);
        chk("rst_ab", {d2_a, d2_b}, 0);
        chk("rst_err", d2_err, 0);
        chk("rst_fail", {d2_fv, d2_fvec}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run(0, -1, -1, dat, nd, abq);
        chk("ok_done_at", dat, 12);
        chk("ok_ndone", nd, 1);
        chk("ok_ab_seq", abq, 8'he4);
        chk("ok_pass", d2_pass, 1);
        chk("ok_err", d2_err, 6'b000000);
        chk("ok_fv", d2_fv, 0);
        chk("ok_busy_after", d2_busy, 0);

        f0 = 6'b001000;
        run(0, -1, -1, dat, nd, abq);
        chk("and0_done_at", dat, 12);
        chk("and0_err", d2_err, 6'b001000);
        chk("and0_fvec", d2_fvec, 3);
        chk("and0_fv", d2_fv, 1);
        chk("and0_pass", d2_pass, 0);

        f0 = 6'h00;
        f1 = 6'b000001;
        run(0, -1, -1, dat, nd, abq);
        chk("not1_err", d2_err, 6'b000001);
        chk("not1_fvec", d2_fvec, 2);
        chk("not1_pass", d2_pass, 0);

        f1 = 6'h00;
        run(0, 4, -1, dat, nd, abq);
        chk("ign_done_at", dat, 12);
        chk("ign_ndone", nd, 1);
        chk("ign_pass", d2_pass, 1);

        run(0, -1, 5, dat, nd, abq);
        chk("abt_busy", d2_busy, 0);
        chk("abt_ab", {d2_a, d2_b}, 0);
        chk("abt_ndone", nd, 0);
        chk("abt_pass", d2_pass, 0);
        run(0, -1, -1, dat, nd, abq);
        chk("restart_done_at", dat, 12);
        chk("restart_pass", d2_pass, 1);

        run(1, -1, -1, dat, nd, abq);
        chk("s1_done_at", dat, 8);
        chk("s1_ndone", nd, 1);
        chk("s1_ab_seq", abq, 8'he4);
        chk("s1_pass", d1_pass, 1);

        f0 = 6'b000001;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_ab", {d2_a, d2_b}, 2'b01);
        chk("pre_rst_busy", d2_busy, 1);
        chk("pre_rst_err", d2_err, 6'b000001);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", d2_busy, 0);
        chk("mid_rst_ab", {d2_a, d2_b}, 0);
        chk("mid_rst_err", d2_err, 0);
        chk("mid_rst_fv", d2_fv, 0);
        chk("mid_rst_done", d2_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        f0 = 6'h00;
        run(0, -1, -1, dat, nd, abq);
        chk("post_rst_done_at", dat, 12);
        chk("post_rst_pass", d2_pass, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gate_bank_sequencer.md
Name: gate_bank_sequencer

Overview:
Self-test controller for the six-gate logic bank (NOT, NOT, OR, AND, XOR, XNOR on inputs a/b, 6-bit result bus).
- On start, walks all four (a,b) operand combinations, waits a settle time, samples the bank's 6-bit output and compares it against an internal truth table.
- Reports pass/fail, a sticky per-gate error mask, and the first failing vector.
- Sits beside the gate bank: drives its a/b inputs and observes its out bus.

Parameters:
SETTLE_CYCLES, 2, cycles between driving a vector and sampling gate_out; legal range 1..15
GATE_W, 6, width of the gate result bus; fixed at 6, not intended for override

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a run; honoured only in IDLE
abort  input  1  synchronous abort; returns to IDLE without done
gate_out  input  6  result bus from the gate bank
a  output  1  operand a to the gate bank (registered)
b  output  1  operand b to the gate bank (registered)
busy  output  1  high from the cycle after start is accepted until DONE is left
done  output  1  one-cycle pulse at end of a completed run
pass  output  1  1 when the last completed run had err_mask==0; held until next start
err_mask  output  6  sticky per-bit mismatch mask for the current/last run
fail_valid  output  1  at least one mismatch recorded this run
fail_vec  output  2  vector index {a,b} of the first mismatching vector

Behaviour:
- Reset (rst_n low, async): state=IDLE; a=b=0, busy=0, done=0, pass=0, err_mask=0, fail_valid=0, fail_vec=0, vec=0, cnt=0.
- Vector order: vec 0..3; a=vec[1], b=vec[0] (00,01,10,11).
- Expected bus for (a,b): bit0=~a, bit1=~a, bit2=a|b, bit3=a&b, bit4=a^b, bit5=~(a^b).
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE: start=1 and abort=0 -> SETTLE next cycle. Same edge: vec=0, a=b=0, cnt=0, err_mask=0, fail_valid=0, fail_vec=0, pass=0.
- SETTLE: cnt increments each cycle. At cnt==SETTLE_CYCLES-1, go to CHECK.
- CHECK (one cycle):
  - mism = gate_out ^ expected(a,b); err_mask |= mism.
  - If mism!=0 and fail_valid==0: fail_vec=vec, fail_valid=1.
  - If vec==3: go to DONE. Else vec+1, a/b update, cnt=0, go to SETTLE.
- DONE (one cycle): done=1, pass=(err_mask==0); next state is IDLE.
- busy=1 in SETTLE, CHECK and DONE.
- Latency: start sampled at edge 0 -> done high during cycle 4*(SETTLE_CYCLES+1)+1. SETTLE_CYCLES=2 gives cycle 13.
- start while busy: ignored, no effect on the run.
- abort in any non-IDLE state:
  - Next state IDLE, a=b=0, busy=0, no done pulse, pass=0.
  - err_mask, fail_valid and fail_vec keep their partial values.
- abort and start in the same IDLE cycle: abort wins, stays IDLE.
- abort in the DONE cycle: done still pulses that cycle; IDLE next, as normal.
- Reset mid-run: immediate return to reset values, no done.
- Results (pass, err_mask, fail_*) are held in IDLE until the next accepted start.

Decomposition:
- Package gate_seq_pkg:
  - state enum (IDLE, SETTLE, CHECK, DONE)
  - localparams NUM_VECTORS=4, GATE_W=6
  - function gate_expected(a,b) returning the 6-bit truth-table value
- No sub-module. One FSM plus the vec/cnt counters in a single module; the package function is the reference model.

Test Plan:
- SETTLE_CYCLES=2, fault-free gate bank connected; start pulse at cycle 0 -> a/b step 00,01,10,11; done=1 exactly at cycle 13; pass=1, err_mask=6'b000000, fail_valid=0.
- gate_out[3] forced 0 -> mismatch only at vec 3; err_mask=6'b001000, fail_vec=2'd3, fail_valid=1, pass=0.
- gate_out[0] forced 1 -> mismatch at vec 2 and 3; err_mask=6'b000001, fail_vec=2'd2, pass=0.
- abort at cycle 5 of a run -> busy=0 and a=b=0 from cycle 6, no done pulse; a start at cycle 6 restarts and gives done 13 cycles later. Also: a start pulse at cycle 4 of a run is ignored, and done still arrives at cycle 13.
- SETTLE_CYCLES=1 -> done at cycle 9. Reset asserted mid-SETTLE -> all outputs return to zero asynchronously, and a new start after release runs normally.
